// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction/data memory-port arbiter:
// FSM encoding, the NOP word returned on timeout, and the latched memory command.
package riscv_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT_I = 2'd1;
  localparam logic [1:0] ST_GRANT_D = 2'd2;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/arb_timeout_ctr.sv
// Counts cycles an outstanding memory access waits for mem_ready and flags
// the cycle on which the wait reaches TIMEOUT_CYC.
module arb_timeout_ctr #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_active,
  input  logic i_ready,
  output logic o_timeout
);

  localparam int CW = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] r_cnt;

  // Fires during the TIMEOUT_CYC-th consecutive wait cycle, so the abort
  // lands on the following edge.
  assign o_timeout = i_active && !i_ready && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              r_cnt <= '0;
    else if (!i_active || i_ready || o_timeout) r_cnt <= '0;
    else                                     r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between instruction fetch and data load/store,
// with bounded data priority (anti-starvation) and a mem_ready timeout.
module mem_port_arbiter
  import riscv_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT_CYC  = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        stall_f,
  output logic        stall_m,
  output logic        err
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [1:0]    r_state;
  logic [SW-1:0] r_starve;
  mem_cmd_t      r_cmd;
  logic          r_mem_req, r_if_valid, r_d_valid, r_err;
  logic [31:0]   r_if_rdata, r_d_rdata;

  logic        w_in_idle, w_can_grant, w_grant_d, w_grant_i;
  logic        w_busy, w_timeout, w_finish;
  logic [31:0] w_rdata;

  // No grant during a completion pulse: the finishing requester must see
  // its valid before competing again.
  assign w_in_idle   = (r_state == ST_IDLE);
  assign w_can_grant = w_in_idle && !r_if_valid && !r_d_valid;
  assign w_grant_d   = w_can_grant && d_req && ((r_starve < SW'(STARVE_LIMIT)) || !if_req);
  assign w_grant_i   = w_can_grant && if_req && !w_grant_d;
  assign w_busy      = !w_in_idle;
  assign w_finish    = w_busy && (mem_ready || w_timeout);
  assign w_rdata     = mem_ready ? mem_rdata : NOP_INSN;

  arb_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
    .clk       (clk),
    .rst_n     (reset),
    .i_active  (w_busy),
    .i_ready   (mem_ready),
    .o_timeout (w_timeout)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_cmd      <= '0;
      r_mem_req  <= 1'b0;
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;
      if (w_timeout) r_err <= 1'b1;
      if (w_grant_d) begin
        r_state   <= ST_GRANT_D;
        r_mem_req <= 1'b1;
        r_cmd     <= '{we: d_we, addr: d_addr, wdata: d_wdata};
      end else if (w_grant_i) begin
        r_state   <= ST_GRANT_I;
        r_mem_req <= 1'b1;
        r_cmd     <= '{we: 1'b0, addr: if_addr, wdata: 32'h0};
      end else if (w_finish) begin
        r_state   <= ST_IDLE;
        r_mem_req <= 1'b0;
        if (r_state == ST_GRANT_I) begin
          r_if_valid <= 1'b1;
          r_if_rdata <= w_rdata;
        end else begin
          r_d_valid <= 1'b1;
          r_d_rdata <= w_rdata;
        end
      end
    end
  end

  // Counts back-to-back data grants that overtook a waiting fetch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                   r_starve <= '0;
    else if (w_grant_i)           r_starve <= '0;
    else if (w_grant_d && if_req) begin
      if (r_starve != SW'(STARVE_LIMIT)) r_starve <= r_starve + 1'b1;
    end
    else if (w_in_idle && !if_req) r_starve <= '0;
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_cmd.we;
  assign mem_addr  = r_cmd.addr;
  assign mem_wdata = r_cmd.wdata;
  assign if_valid  = r_if_valid;
  assign if_rdata  = r_if_rdata;
  assign d_valid   = r_d_valid;
  assign d_rdata   = r_d_rdata;
  assign err       = r_err;
  assign stall_f   = if_req & ~r_if_valid;
  assign stall_m   = d_req & ~r_d_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, corner
// sequences (ordering, starvation, timeout, reset abort) and random traffic.
module tb_mem_port_arbiter;

  localparam int STARVE = 4;
  localparam int TMO    = 8;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ready = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_valid, d_valid, mem_req, mem_we, stall_f, stall_m, err;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(STARVE), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall_f(stall_f), .stall_m(stall_m), .err(err)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        if_req;
    logic        d_req;
    logic        d_we;
    logic [31:0] if_addr;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] rdata;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic        exp_dv;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[5];

  // Transaction-level reference: who owns the port, what was captured,
  // how long it has waited, and how many data grants overtook a fetch.
  int          m_owner, m_waited, m_streak;   // owner: 0 none, 1 fetch, 2 data
  logic        m_we, m_ifv, m_dv, m_err;
  logic [31:0] m_addr, m_wdata, m_ifr, m_dr;

  task automatic model_reset();
    m_owner = 0; m_waited = 0; m_streak = 0;
    m_we = 0; m_ifv = 0; m_dv = 0; m_err = 0;
    m_addr = '0; m_wdata = '0; m_ifr = '0; m_dr = '0;
  endtask

  task automatic model_step();
    bit was_pulse;
    logic [31:0] rd;
    was_pulse = m_ifv | m_dv;
    m_ifv = 0;
    m_dv  = 0;
    if (m_owner == 0) begin
      if (!was_pulse && d_req && (!if_req || m_streak < STARVE)) begin
        m_owner = 2; m_we = d_we; m_addr = d_addr; m_wdata = d_wdata; m_waited = 0;
        if (if_req) m_streak = m_streak + 1;
      end else if (!was_pulse && if_req) begin
        m_owner = 1; m_we = 0; m_addr = if_addr; m_wdata = 0; m_waited = 0;
        m_streak = 0;
      end
      if (!if_req) m_streak = 0;
    end else if (mem_ready || (m_waited + 1 == TMO)) begin
      rd = mem_ready ? mem_rdata : NOP;
      if (!mem_ready) m_err = 1;
      if (m_owner == 1) begin m_ifv = 1; m_ifr = rd; end
      else              begin m_dv  = 1; m_dr  = rd; end
      m_owner = 0;
    end else begin
      m_waited++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       first, fseen, done, prev;
    logic [4:0] pat;
    int         ng, reqc, cnt;

    // Reset state; stalls stay combinational while reset is held.
    if_req = 1; d_req = 1;
    @(negedge clk);
    chk("rst ctrl", {mem_req, mem_we, if_valid, d_valid, err}, 5'b0);
    chk("rst data", {mem_addr, mem_wdata, if_rdata, d_rdata}, 128'h0);
    chk("rst stall", {stall_f, stall_m}, 2'b11);
    if_req = 0; d_req = 0;
    @(negedge clk); reset = 1;
    @(negedge clk);

    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 32'h00500093,
                1'b0, 32'h100, 32'h0, 1'b0, 32'h00500093};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 32'h104, 32'h2000, 32'hDEADBEEF, 32'h12345678,
                1'b1, 32'h2000, 32'hDEADBEEF, 1'b1, 32'h12345678};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h3004, 32'h55AA55AA, 32'hA5A50001,
                1'b0, 32'h3004, 32'h55AA55AA, 1'b1, 32'hA5A50001};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 32'hFFFFFFFC, 32'h0, 32'h0, 32'hFFFFFFFF,
                1'b0, 32'hFFFFFFFC, 32'h0, 1'b0, 32'hFFFFFFFF};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0,
                1'b1, 32'h0, 32'h0, 1'b1, 32'h0};

    foreach (vecs[k]) begin
      @(negedge clk);
      if_req = vecs[k].if_req; d_req = vecs[k].d_req; d_we = vecs[k].d_we;
      if_addr = vecs[k].if_addr; d_addr = vecs[k].d_addr; d_wdata = vecs[k].d_wdata;
      mem_rdata = vecs[k].rdata; mem_ready = 1;
      @(negedge clk);
      chk($sformatf("vec%0d mem_req", k), mem_req, 1'b1);
      chk($sformatf("vec%0d cmd", k), {mem_we, mem_addr, mem_wdata},
          {vecs[k].exp_we, vecs[k].exp_addr, vecs[k].exp_wdata});
      chk($sformatf("vec%0d stall", k), {stall_f, stall_m}, {vecs[k].if_req, vecs[k].d_req});
      if_req = 0; d_req = 0;
      @(negedge clk);
      chk($sformatf("vec%0d valid", k), {if_valid, d_valid, mem_req},
          {~vecs[k].exp_dv, vecs[k].exp_dv, 1'b0});
      chk($sformatf("vec%0d rdata", k), vecs[k].exp_dv ? d_rdata : if_rdata, vecs[k].exp_rd);
      @(negedge clk);
      chk($sformatf("vec%0d pulse end", k), {if_valid, d_valid}, 2'b00);
    end

    // Simultaneous store + fetch: store first, fetch next, fetch stalled meanwhile.
    @(negedge clk);
    if_req = 1; if_addr = 32'h300; d_req = 1; d_we = 1; d_addr = 32'h2000;
    d_wdata = 32'hDEADBEEF; mem_ready = 1; mem_rdata = 32'h0;
    first = 0; fseen = 0; done = 0;
    for (int i = 0; i < 12 && !done; i++) begin
      @(negedge clk);
      if (mem_req && !first) begin
        first = 1;
        chk("sim first grant", {mem_we, mem_addr, mem_wdata}, {1'b1, 32'h2000, 32'hDEADBEEF});
      end
      if ((mem_req && mem_we) || d_valid) chk("sim stall_f", stall_f, 1'b1);
      if (mem_req && !mem_we) begin fseen = 1; chk("sim fetch addr", mem_addr, 32'h300); end
      if (d_valid) d_req = 0;
      if (if_valid) done = 1;
    end
    chk("sim order done", {first, fseen, done}, 3'b111);
    if_req = 0;
    @(negedge clk); @(negedge clk);

    // Data held with fetch waiting: four data grants, then the fetch.
    if_req = 1; if_addr = 32'h200; d_req = 1; d_we = 0; d_addr = 32'h4000; mem_ready = 1;
    pat = '0; ng = 0; prev = 0;
    for (int i = 0; i < 60 && ng < 5; i++) begin
      @(negedge clk);
      if (mem_req && !prev) begin pat = {pat[3:0], mem_addr == 32'h4000}; ng++; end
      prev = mem_req;
    end
    chk("starve grants", ng, 5);
    chk("starve order", pat, 5'b11110);
    if_req = 0; d_req = 0;
    @(negedge clk); @(negedge clk); @(negedge clk);

    // mem_ready while idle does nothing.
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (if_valid || d_valid || mem_req) cnt++;
    end
    chk("idle ready ignored", cnt, 0);

    // Timeout: mem_ready never arrives.
    d_req = 1; d_we = 0; d_addr = 32'h5000; mem_ready = 0; mem_rdata = 32'hFFFF0000;
    reqc = 0; done = 0;
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge clk);
      if (mem_req) begin
        reqc++;
        if (reqc == 3) chk("tmo wait stall/err", {stall_m, err}, 2'b10);
      end
      if (d_valid) begin
        done = 1;
        chk("tmo req cycles", reqc, TMO);
        chk("tmo nop", d_rdata, NOP);
        chk("tmo err/req", {err, mem_req}, 2'b10);
        d_req = 0;
      end
    end
    chk("tmo seen", done, 1'b1);
    @(negedge clk);
    if_req = 1; if_addr = 32'h400; mem_ready = 1;
    @(negedge clk);
    if_req = 0;
    @(negedge clk);
    chk("err sticky", {err, if_valid}, 2'b11);
    @(negedge clk);

    // Reset while a store waits: immediate clear, no stale completion.
    d_req = 1; d_we = 1; d_addr = 32'h6000; d_wdata = 32'h11112222; mem_ready = 0;
    @(negedge clk);
    chk("rstmid granted", mem_req, 1'b1);
    @(negedge clk); @(negedge clk);
    #2 reset = 0; if_req = 1; d_req = 0;
    #1;
    chk("rstmid ctrl", {mem_req, mem_we, if_valid, d_valid, err}, 5'b0);
    chk("rstmid data", {mem_addr, mem_wdata, if_rdata, d_rdata}, 128'h0);
    chk("rstmid stall", {stall_f, stall_m}, 2'b10);
    @(negedge clk); if_req = 0; mem_ready = 1;
    @(negedge clk); reset = 1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (d_valid || if_valid || mem_req) cnt++;
    end
    chk("rstmid no pulse", cnt, 0);

    // Random traffic against the reference model.
    reset = 0; if_req = 0; d_req = 0; mem_ready = 0;
    @(negedge clk); @(negedge clk);
    reset = 1;
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      chk($sformatf("rnd%0d ctrl", c), {mem_req, if_valid, d_valid, err, stall_f, stall_m},
          {m_owner != 0, m_ifv, m_dv, m_err, if_req & ~m_ifv, d_req & ~m_dv});
      chk($sformatf("rnd%0d rdata", c), {if_rdata, d_rdata}, {m_ifr, m_dr});
      if (m_owner != 0)
        chk($sformatf("rnd%0d cmd", c), {mem_we, mem_addr, mem_wdata}, {m_we, m_addr, m_wdata});
      if_req    = ($urandom_range(0, 9) < 6);
      d_req     = ($urandom_range(0, 9) < 6);
      d_we      = $urandom_range(0, 1) == 1;
      if_addr   = $urandom;
      d_addr    = $urandom;
      d_wdata   = $urandom;
      mem_rdata = $urandom;
      mem_ready = (c < 800) ? ($urandom_range(0, 99) < 75) : ($urandom_range(0, 99) < 8);
      @(posedge clk);
      model_step();
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
